alarm_scheduler: RTL and testbench

- Sequences the alarm resource of the digital clock: detects time/alarm match, drives ringing and buzzer pattern, and handles snooze re-arm, dismiss and auto-silence.
- Sits between the clock/alarm counters (read-only hour/minute inputs) and the top-level button FSM, which supplies debounced single-cycle button pulses and an edit-mode flag.

---
 rtl/alarm_scheduler.sv | 115 +++++++++++
 tb/tb_alarm_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: alarm sequencer detecting time/alarm match, ringing, snooze re-arm, dismiss and optional auto-silence.
// Ports: clk_i/rst_ni (async active-low) clock and reset; tick_1hz_i one-cycle pulse per second;
//        time_hour_i/time_min_i and alarm_hour_i/alarm_min_i counter values; alarm_en_i arm level;
//        edit_active_i edit-mode level; snooze_btn_i/dismiss_btn_i one-cycle button pulses;
//        ringing_o, snoozing_o, buzzer_o, snooze_cnt_o registered status outputs.
// Optional feature: define ALARM_RING_TIMEOUT_EN to auto-silence after RING_TIMEOUT_SEC ticks of ringing.
module alarm_scheduler #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3,
  parameter int CNT_W            = 9
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_1hz_i,
  input  logic [4:0] time_hour_i,
  input  logic [5:0] time_min_i,
  input  logic [4:0] alarm_hour_i,
  input  logic [5:0] alarm_min_i,
  input  logic       alarm_en_i,
  input  logic       edit_active_i,
  input  logic       snooze_btn_i,
  input  logic       dismiss_btn_i,
  output logic       ringing_o,
  output logic       snoozing_o,
  output logic       buzzer_o,
  output logic [1:0] snooze_cnt_o
);
  typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZE} state_e;
  localparam int MAX_SEC = SNOOZE_SEC > RING_TIMEOUT_SEC ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  if (MAX_SEC >= (1 << CNT_W)) begin : g_cnt_w_too_small
    $error("CNT_W too narrow for SNOOZE_SEC/RING_TIMEOUT_SEC");
  end
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             beep_q, beep_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             match, match_prev_q, trigger;
  assign match        = (time_hour_i == alarm_hour_i) && (time_min_i == alarm_min_i);
  // rising edge only: one ring per matching minute, and leaving edit mid-match stays silent
  assign trigger      = match && !match_prev_q && !edit_active_i;
  assign snooze_cnt_o = cnt_q;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    beep_d  = beep_q;
    cnt_d   = cnt_q;
    if (!alarm_en_i) begin
      state_d = DISARMED;
      timer_d = '0;
      beep_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: if (trigger) begin
          state_d = RINGING;
          timer_d = '0;
          beep_d  = 1'b1;
          cnt_d   = '0;
        end
        RINGING: if (dismiss_btn_i) begin
          state_d = ARMED;
          timer_d = '0;
          cnt_d   = '0;
        end else if (snooze_btn_i && cnt_q < 2'(MAX_SNOOZE)) begin
          state_d = SNOOZE;
          timer_d = CNT_W'(SNOOZE_SEC);
          cnt_d   = cnt_q + 2'd1;
        end else if (tick_1hz_i) begin
          beep_d = !beep_q;
`ifdef ALARM_RING_TIMEOUT_EN
          timer_d = timer_q + CNT_W'(1);
          if (timer_q == CNT_W'(RING_TIMEOUT_SEC - 1)) begin
            state_d = ARMED;
            timer_d = '0;
            cnt_d   = '0;
          end
`endif
        end
        SNOOZE: if (dismiss_btn_i) begin
          state_d = ARMED;
          timer_d = '0;
          cnt_d   = '0;
        end else if (tick_1hz_i) begin
          state_d = timer_q == CNT_W'(1) ? RINGING : SNOOZE;
          timer_d = timer_q == CNT_W'(1) ? '0 : timer_q - CNT_W'(1);
          beep_d  = timer_q == CNT_W'(1) ? 1'b1 : beep_q;
        end
        default: state_d = DISARMED;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DISARMED;
      timer_q      <= '0;
      beep_q       <= 1'b0;
      cnt_q        <= '0;
      match_prev_q <= 1'b1;
      ringing_o    <= 1'b0;
      snoozing_o   <= 1'b0;
      buzzer_o     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      beep_q       <= beep_d;
      cnt_q        <= cnt_d;
      match_prev_q <= match;
      ringing_o    <= state_d == RINGING;
      snoozing_o   <= state_d == SNOOZE;
      buzzer_o     <= (state_d == RINGING) && beep_d;
    end
  end
endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: directed scoreboard bench for alarm_scheduler.
module tb_alarm_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, snz = 1'b0, dis = 1'b0, en = 1'b1, edit = 1'b0;
  logic [4:0] t_h = '0, a_h = '0;
  logic [5:0] t_m = '0, a_m = '0;
  logic       ringing, snoozing, buzzer;
  logic [1:0] cnt;
  int         n_assert = 0, n_fail = 0;
  typedef struct {string tag; logic [4:0] v;} exp_t;
  exp_t sb[$];
  alarm_scheduler #(.SNOOZE_SEC(3), .RING_TIMEOUT_SEC(5), .MAX_SNOOZE(2), .CNT_W(9)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_1hz_i(tick),
    .time_hour_i(t_h), .time_min_i(t_m), .alarm_hour_i(a_h), .alarm_min_i(a_m),
    .alarm_en_i(en), .edit_active_i(edit), .snooze_btn_i(snz), .dismiss_btn_i(dis),
    .ringing_o(ringing), .snoozing_o(snoozing), .buzzer_o(buzzer), .snooze_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic push(input string tag, input logic r, s, b, input logic [1:0] c);
    exp_t e;
    e.tag = tag;
    e.v   = {r, s, b, c};
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [4:0] obs;
    e   = sb.pop_front();
    obs = {ringing, snoozing, buzzer, cnt};
    n_assert++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed ring/snz/buz/cnt=%b expected %b", e.tag, obs, e.v);
    end
  endtask
  task automatic cyc(input logic tk, sn, dm, input string tag, input logic r, s, b, input logic [1:0] c);
    tick = tk;
    snz  = sn;
    dis  = dm;
    push(tag, r, s, b, c);
    @(posedge clk);
    #1;
    tick = 1'b0;
    snz  = 1'b0;
    dis  = 1'b0;
    check();
  endtask
  task automatic ring_at_0730(input string tag);
    t_m = 6'd31;
    cyc(0, 0, 0, "pre_ring", 0, 0, 0, 0);
    t_m = 6'd30;
    cyc(0, 0, 0, tag, 1, 0, 1, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 0, 0);
    check();
    rst_n = 1'b1;
    cyc(0, 0, 0, "armed_idle", 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) cyc(1, 0, 0, "no_ring_after_reset", 0, 0, 0, 0);
    a_h = 5'd7; a_m = 6'd30; t_h = 5'd7; t_m = 6'd29;
    cyc(0, 0, 0, "0729_idle", 0, 0, 0, 0);
    t_m = 6'd30;
    cyc(0, 0, 0, "ring", 1, 0, 1, 0);
    cyc(1, 0, 0, "beep_off", 1, 0, 0, 0);
    cyc(1, 0, 0, "beep_on", 1, 0, 1, 0);
    cyc(0, 0, 0, "beep_hold", 1, 0, 1, 0);
    cyc(0, 0, 1, "dismiss", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, "no_retrigger", 0, 0, 0, 0);
    ring_at_0730("ring_next_day");
    cyc(0, 1, 0, "snooze1", 0, 1, 0, 1);
    cyc(1, 0, 0, "snz1_t1", 0, 1, 0, 1);
    cyc(1, 0, 0, "snz1_t2", 0, 1, 0, 1);
    cyc(1, 0, 0, "rering1", 1, 0, 1, 1);
    cyc(0, 1, 0, "snooze2", 0, 1, 0, 2);
    cyc(0, 1, 0, "snooze_in_snooze", 0, 1, 0, 2);
    cyc(1, 0, 0, "snz2_t1", 0, 1, 0, 2);
    cyc(1, 0, 0, "snz2_t2", 0, 1, 0, 2);
    cyc(1, 0, 0, "rering2", 1, 0, 1, 2);
    cyc(0, 1, 0, "snooze_max_ignored", 1, 0, 1, 2);
    cyc(0, 1, 1, "dismiss_and_snooze", 0, 0, 0, 0);
    ring_at_0730("ring_tick_test");
    cyc(1, 1, 0, "snooze_on_tick", 0, 1, 0, 1);
    cyc(1, 0, 0, "snz_tick_a", 0, 1, 0, 1);
    cyc(1, 0, 0, "snz_tick_b", 0, 1, 0, 1);
    cyc(1, 0, 0, "rering_tick_uncounted", 1, 0, 1, 1);
    cyc(0, 1, 0, "snooze_b", 0, 1, 0, 2);
    cyc(1, 0, 1, "dismiss_on_tick", 0, 0, 0, 0);
    t_m = 6'd31;
    cyc(0, 0, 0, "pre_edit", 0, 0, 0, 0);
    edit = 1'b1;
    t_m  = 6'd30;
    cyc(0, 0, 0, "edit_match", 0, 0, 0, 0);
    edit = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, "edit_exit_no_ring", 0, 0, 0, 0);
    ring_at_0730("ring_pre_disarm");
    cyc(0, 1, 0, "snooze_pre_disarm", 0, 1, 0, 1);
    en = 1'b0;
    cyc(1, 0, 0, "disarm_in_snooze", 0, 0, 0, 0);
    en = 1'b1;
    cyc(0, 0, 0, "rearm", 0, 0, 0, 0);
    cyc(1, 0, 0, "rearm_no_ring", 0, 0, 0, 0);
    ring_at_0730("ring_timeout_test");
`ifdef ALARM_RING_TIMEOUT_EN
    for (int k = 1; k < 5; k++) cyc(1, 0, 0, "ring_before_timeout", 1, 0, (k % 2 == 0), 0);
    cyc(1, 0, 0, "timeout_silence", 0, 0, 0, 0);
`else
    for (int k = 1; k <= 100; k++) cyc(1, 0, 0, "ring_persists", 1, 0, (k % 2 == 0), 0);
    cyc(0, 0, 1, "dismiss_after_persist", 0, 0, 0, 0);
`endif
    ring_at_0730("ring_pre_async_rst");
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 0, 0, 0, 0);
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, "post_reset_no_ring", 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
